zeroriscy_int_controller: RTL and testbench

//  Sits directly upstream of the control/status registers. Samples the external

---
 rtl/zeroriscy_int_controller.sv | 108 ++++++++++
 tb/tb_zeroriscy_int_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_int_controller.sv
// ----------------------------------------------------------------------------
// Module  : zeroriscy_int_controller
// Brief   : Samples the external interrupt, gates it with mstatus.MIE, holds one
//           pending request for the controller and acknowledges it to the source.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module zeroriscy_int_controller #(
  parameter int SYNC_IRQ = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_i,
  input  logic [4:0] irq_id_i,
  input  logic       m_irq_enable_i,
  input  logic       ctrl_ack_i,
  input  logic       ctrl_kill_i,
  output logic       irq_req_ctrl_o,
  output logic [4:0] irq_id_ctrl_o,
  output logic [5:0] csr_cause_o,
  output logic       irq_ack_o,
  output logic [4:0] irq_id_o,
  output logic       irq_taken_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [4:0] id_q;
  logic [4:0] id_d;
  logic       irq_s;

  // The id is deliberately not synchronized: the source holds it stable while
  // irq_i is high, so it is settled by the time the synchronized request arrives.
  generate
    if (SYNC_IRQ != 0) begin : g_sync
      logic [1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= 2'b00;
        end else begin
          sync_q <= {sync_q[0], irq_i};
        end
      end

      assign irq_s = sync_q[1];
    end else begin : g_direct
      assign irq_s = irq_i;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Acknowledge wins over kill and enable drop so a cause the controller has
  // already saved is always reported back to the event unit.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (irq_s && m_irq_enable_i) begin
          id_d    = irq_id_i;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (ctrl_ack_i) begin
          state_d = ACK;
        end else if (ctrl_kill_i) begin
          state_d = IDLE;
        end else if (!m_irq_enable_i) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign irq_req_ctrl_o = (state_q == PENDING);
  assign irq_id_ctrl_o  = (state_q == PENDING) ? id_q : 5'd0;
  assign csr_cause_o    = {1'b1, id_q};
  assign irq_ack_o      = (state_q == ACK);
  assign irq_id_o       = (state_q == ACK) ? id_q : 5'd0;
  assign irq_taken_o    = (state_q == ACK);

endmodule

`default_nettype wire

// File: tb/tb_zeroriscy_int_controller.sv
// ----------------------------------------------------------------------------
// Module  : tb_zeroriscy_int_controller
// Brief   : Directed bench for both synchronizer settings with a scoreboard queue.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_zeroriscy_int_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq;
  logic [4:0] irq_id;
  logic       mie;
  logic       ack;
  logic       kill;

  logic       req0, ack0, tkn0, req1, ack1, tkn1;
  logic [4:0] idc0, ido0, idc1, ido1;
  logic [5:0] cause0, cause1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         dut;
    logic       req;
    logic [4:0] idc;
    logic [5:0] cause;
    logic       ack;
    logic [4:0] ido;
    logic       taken;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  zeroriscy_int_controller #(.SYNC_IRQ(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_id_i(irq_id),
    .m_irq_enable_i(mie), .ctrl_ack_i(ack), .ctrl_kill_i(kill),
    .irq_req_ctrl_o(req0), .irq_id_ctrl_o(idc0), .csr_cause_o(cause0),
    .irq_ack_o(ack0), .irq_id_o(ido0), .irq_taken_o(tkn0)
  );

  zeroriscy_int_controller #(.SYNC_IRQ(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_id_i(irq_id),
    .m_irq_enable_i(mie), .ctrl_ack_i(ack), .ctrl_kill_i(kill),
    .irq_req_ctrl_o(req1), .irq_id_ctrl_o(idc1), .csr_cause_o(cause1),
    .irq_ack_o(ack1), .irq_id_o(ido1), .irq_taken_o(tkn1)
  );

  task automatic cmp(input string tag, input string f, input logic [5:0] got, input logic [5:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s got=%0h exp=%0h", tag, f, got, want);
    end
  endtask

  task automatic expect_out(input int d, input logic r, input logic [4:0] ic, input logic [5:0] c,
                            input logic a, input logic [4:0] io, input logic t, input string tag);
    exp_t e;
    e.dut = d; e.req = r; e.idc = ic; e.cause = c; e.ack = a; e.ido = io; e.taken = t; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        cmp(e.tag, "req",   {5'd0, req0}, {5'd0, e.req});
        cmp(e.tag, "idc",   {1'b0, idc0}, {1'b0, e.idc});
        cmp(e.tag, "cause", cause0,       e.cause);
        cmp(e.tag, "ack",   {5'd0, ack0}, {5'd0, e.ack});
        cmp(e.tag, "ido",   {1'b0, ido0}, {1'b0, e.ido});
        cmp(e.tag, "taken", {5'd0, tkn0}, {5'd0, e.taken});
      end else begin
        cmp(e.tag, "req",   {5'd0, req1}, {5'd0, e.req});
        cmp(e.tag, "idc",   {1'b0, idc1}, {1'b0, e.idc});
        cmp(e.tag, "cause", cause1,       e.cause);
        cmp(e.tag, "ack",   {5'd0, ack1}, {5'd0, e.ack});
        cmp(e.tag, "ido",   {1'b0, ido1}, {1'b0, e.ido});
        cmp(e.tag, "taken", {5'd0, tkn1}, {5'd0, e.taken});
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic tick_check();
    @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic drive(input logic i, input logic [4:0] id, input logic m, input logic a, input logic k);
    irq = i; irq_id = id; mie = m; ack = a; kill = k;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 5'd0, 0, 0, 0);
    @(negedge clk);
    expect_out(0, 0, 5'd0, 6'h20, 0, 5'd0, 0, "rst0");
    expect_out(1, 0, 5'd0, 6'h20, 0, 5'd0, 0, "rst1");
    check_now();

    rst_n = 1'b1;
    expect_out(0, 0, 5'd0, 6'h20, 0, 5'd0, 0, "idle0");
    expect_out(1, 0, 5'd0, 6'h20, 0, 5'd0, 0, "idle1");
    tick_check();

    // basic request / ack, id 11
    drive(1, 5'd11, 1, 0, 0);
    expect_out(0, 1, 5'd11, 6'h2B, 0, 5'd0, 0, "t1_c1");
    tick_check();
    expect_out(0, 1, 5'd11, 6'h2B, 0, 5'd0, 0, "t1_c2");
    tick_check();
    expect_out(0, 1, 5'd11, 6'h2B, 0, 5'd0, 0, "t1_c3");
    tick_check();
    drive(1, 5'd11, 1, 1, 0);
    expect_out(0, 0, 5'd0, 6'h2B, 1, 5'd11, 1, "t1_ack");
    tick_check();
    drive(0, 5'd11, 1, 0, 0);
    expect_out(0, 0, 5'd0, 6'h2B, 0, 5'd0, 0, "t1_post");
    tick_check();

    // MIE gating
    drive(1, 5'd7, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      expect_out(0, 0, 5'd0, 6'h2B, 0, 5'd0, 0, "t2_mie0");
      tick_check();
    end
    drive(1, 5'd7, 1, 0, 0);
    expect_out(0, 1, 5'd7, 6'h27, 0, 5'd0, 0, "t2_mie1");
    tick_check();

    // kill, then re-request while irq still high
    drive(0, 5'd7, 1, 0, 1);
    expect_out(0, 0, 5'd0, 6'h27, 0, 5'd0, 0, "t3_kill7");
    tick_check();
    drive(1, 5'd3, 1, 0, 0);
    expect_out(0, 1, 5'd3, 6'h23, 0, 5'd0, 0, "t3_pend3");
    tick_check();
    drive(1, 5'd3, 1, 0, 1);
    expect_out(0, 0, 5'd0, 6'h23, 0, 5'd0, 0, "t3_kill3");
    tick_check();
    drive(1, 5'd3, 1, 0, 0);
    expect_out(0, 1, 5'd3, 6'h23, 0, 5'd0, 0, "t3_rereq");
    tick_check();

    // irq drop does not withdraw; MIE drop does; new id ignored while pending
    drive(0, 5'd30, 1, 0, 0);
    expect_out(0, 1, 5'd3, 6'h23, 0, 5'd0, 0, "hold");
    tick_check();
    drive(0, 5'd30, 0, 0, 0);
    expect_out(0, 0, 5'd0, 6'h23, 0, 5'd0, 0, "mie_drop");
    tick_check();

    // ack beats kill and MIE drop
    drive(1, 5'd20, 1, 0, 0);
    expect_out(0, 1, 5'd20, 6'h34, 0, 5'd0, 0, "t4_pend");
    tick_check();
    drive(1, 5'd20, 0, 1, 1);
    expect_out(0, 0, 5'd0, 6'h34, 1, 5'd20, 1, "t4_ack");
    tick_check();
    drive(0, 5'd20, 0, 1, 1);
    expect_out(0, 0, 5'd0, 6'h34, 0, 5'd0, 0, "t4_idle");
    tick_check();
    expect_out(0, 0, 5'd0, 6'h34, 0, 5'd0, 0, "ack_in_idle");
    tick_check();

    // asynchronous reset while pending
    drive(1, 5'd9, 1, 0, 0);
    expect_out(0, 1, 5'd9, 6'h29, 0, 5'd0, 0, "t6_pend");
    tick_check();
    drive(1, 5'd9, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(0, 0, 5'd0, 6'h20, 0, 5'd0, 0, "t6_async0");
    expect_out(1, 0, 5'd0, 6'h20, 0, 5'd0, 0, "t6_async1");
    check_now();
    expect_out(0, 0, 5'd0, 6'h20, 0, 5'd0, 0, "t6_inrst");
    tick_check();

    // release with irq high: direct path one cycle, synchronized path three
    drive(1, 5'd9, 1, 0, 0);
    rst_n = 1'b1;
    expect_out(0, 1, 5'd9, 6'h29, 0, 5'd0, 0, "t6_rereq0");
    expect_out(1, 0, 5'd0, 6'h20, 0, 5'd0, 0, "t5_c1");
    tick_check();
    expect_out(1, 0, 5'd0, 6'h20, 0, 5'd0, 0, "t5_c2");
    tick_check();
    expect_out(1, 1, 5'd9, 6'h29, 0, 5'd0, 0, "t5_c3");
    expect_out(0, 1, 5'd9, 6'h29, 0, 5'd0, 0, "t6_stay0");
    tick_check();

    // flush both, let the synchronizer drain
    drive(0, 5'd9, 0, 0, 1);
    expect_out(0, 0, 5'd0, 6'h29, 0, 5'd0, 0, "flush0");
    expect_out(1, 0, 5'd0, 6'h29, 0, 5'd0, 0, "flush1");
    tick_check();
    drive(0, 5'd9, 0, 0, 0);
    tick_check();
    tick_check();
    expect_out(1, 0, 5'd0, 6'h29, 0, 5'd0, 0, "drained1");
    tick_check();

    // one-cycle glitch captured through the synchronizer
    drive(1, 5'd17, 1, 0, 0);
    expect_out(0, 1, 5'd17, 6'h31, 0, 5'd0, 0, "glitch0");
    expect_out(1, 0, 5'd0, 6'h29, 0, 5'd0, 0, "glitch1_c1");
    tick_check();
    drive(0, 5'd17, 1, 0, 0);
    expect_out(1, 0, 5'd0, 6'h29, 0, 5'd0, 0, "glitch1_c2");
    tick_check();
    expect_out(1, 1, 5'd17, 6'h31, 0, 5'd0, 0, "glitch1_c3");
    expect_out(0, 1, 5'd17, 6'h31, 0, 5'd0, 0, "glitch0_hold");
    tick_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
